rtc_match_int_sync: RTL

//  Match/interrupt stage directly upstream of the RTC interrupt-clear logic. Transfers the APB-written

---
 rtl/rtc_pkg.sv | 16 +
 rtl/rtc_match_int_sync_if.sv | 30 +++
 rtl/rtc_sync.sv | 28 ++
 rtl/rtc_match_int_sync.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC match/interrupt slice: default widths and
// the encoding of the PCLK-side match-transfer handshake FSM.
package rtc_pkg;

  localparam int RTC_DATA_WIDTH  = 32;
  localparam int RTC_SYNC_STAGES = 2;

  // Four-phase handshake: IDLE -> REQ (Req high, waiting for Ack) -> REL
  // (Req low, waiting for Ack to drop) -> IDLE or straight back to REQ.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/rtc_match_int_sync_if.sv
// PCLK-side bus of the match/interrupt stage: match write port, interrupt
// mask/clear inputs, and the readback/status/interrupt outputs.
interface rtc_match_int_sync_if
  import rtc_pkg::*;
#(
  parameter int DATA_WIDTH = RTC_DATA_WIDTH
);

  logic                  MatchWrite;
  logic [DATA_WIDTH-1:0] MatchData;
  logic                  IntMask;
  logic                  IntClear;
  logic [DATA_WIDTH-1:0] MatchValue;
  logic                  MatchBusy;
  logic                  RawIntSync;
  logic                  RTCINTR;

  // Driver side (APB register block / interrupt-clear stage).
  modport master (
    output MatchWrite, MatchData, IntMask, IntClear,
    input  MatchValue, MatchBusy, RawIntSync, RTCINTR
  );

  // The match/interrupt stage itself.
  modport slave (
    input  MatchWrite, MatchData, IntMask, IntClear,
    output MatchValue, MatchBusy, RawIntSync, RTCINTR
  );

endinterface

// File: rtl/rtc_sync.sv
// Single-bit multi-flop synchroniser, asynchronous active-low reset to 0.
// STAGES must be at least 2.
module rtc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input in at bit 0; the oldest bit is the output.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rtc_match_int_sync.sv
// RTC match/interrupt stage. PCLK side: match register plus a four-phase
// handshake that ships the match value into the CLK1HZ domain. CLK1HZ side:
// shadow match register, rising-edge count comparator and raw interrupt flag,
// which is synchronised back to PCLK and masked to form RTCINTR.
module rtc_match_int_sync
  import rtc_pkg::*;
#(
  parameter int DATA_WIDTH  = RTC_DATA_WIDTH,
  parameter int SYNC_STAGES = RTC_SYNC_STAGES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  CLK1HZ,
  input  logic                  nRTCRST,
  input  logic [DATA_WIDTH-1:0] CountValue,
  rtc_match_int_sync_if.slave   bus
);

  // ---------------- PCLK domain ----------------
  hs_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] match_value_q, match_value_d;
  logic [DATA_WIDTH-1:0] match_xfer_q, match_xfer_d;
  logic                  req_q, req_d;
  logic                  pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic                  ack_s;
  logic                  raw_int_s;

  // ---------------- CLK1HZ domain ----------------
  logic [DATA_WIDTH-1:0] match_shadow_q, match_shadow_d;
  logic                  ack_q, ack_d;
  logic                  raw_int_q, raw_int_d;
  logic                  hit_dly_q, hit_dly_d;
  logic                  req_prev_q, req_prev_d;
  logic                  req_s;
  logic                  clr_s;
  logic                  hit;

  // Crossings: Req and IntClear into CLK1HZ, Ack and RawInt into PCLK.
  rtc_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk(CLK1HZ), .rst_n(nRTCRST), .d(req_q), .q(req_s)
  );
  rtc_sync #(.STAGES(SYNC_STAGES)) u_clr_sync (
    .clk(CLK1HZ), .rst_n(nRTCRST), .d(bus.IntClear), .q(clr_s)
  );
  rtc_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(PCLK), .rst_n(PRESETn), .d(ack_q), .q(ack_s)
  );
  rtc_sync #(.STAGES(SYNC_STAGES)) u_raw_sync (
    .clk(PCLK), .rst_n(PRESETn), .d(raw_int_q), .q(raw_int_s)
  );

  // PCLK next-state: match register, handshake FSM, pending-write tracking.
  always_comb begin
    state_d       = state_q;
    match_value_d = match_value_q;
    match_xfer_d  = match_xfer_q;
    req_d         = req_q;
    pend_d        = pend_q;

    // Readback register follows every write regardless of transfer state.
    if (bus.MatchWrite) match_value_d = bus.MatchData;

    case (state_q)
      ST_IDLE: begin
        if (bus.MatchWrite) begin
          match_xfer_d = bus.MatchData;
          req_d        = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.MatchWrite) pend_d = 1'b1;
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (bus.MatchWrite) pend_d = 1'b1;
        if (!ack_s) begin
          if (pend_d) begin
            // Only the newest write is shipped; older pending values are dropped.
            match_xfer_d = match_value_d;
            pend_d       = 1'b0;
            req_d        = 1'b1;
            state_d      = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Registered from next-state values so Busy is high right after a write.
    busy_d = (state_d != ST_IDLE) | pend_d;
  end

  // PCLK register set.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      match_value_q <= '0;
      match_xfer_q  <= '0;
      req_q         <= 1'b0;
      pend_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_value_q <= match_value_d;
      match_xfer_q  <= match_xfer_d;
      req_q         <= req_d;
      pend_q        <= pend_d;
      busy_q        <= busy_d;
    end
  end

  // CLK1HZ next-state: capture on Req_s rise, comparator edge detect, raw flag.
  always_comb begin
    match_shadow_d = match_shadow_q;
    ack_d          = ack_q;
    req_prev_d     = req_s;
    hit_dly_d      = hit;
    raw_int_d      = raw_int_q;

    // match_xfer_q is held stable by the PCLK side while Req is high.
    if (req_s && !req_prev_q) begin
      match_shadow_d = match_xfer_q;
      ack_d          = 1'b1;
    end else if (!req_s && req_prev_q) begin
      ack_d = 1'b0;
    end

    // A new match edge wins over a clear arriving on the same edge.
    if (hit && !hit_dly_q) raw_int_d = 1'b1;
    else if (clr_s)        raw_int_d = 1'b0;
  end

  assign hit = (CountValue == match_shadow_q);

  // CLK1HZ register set; hit_dly resets high so count==match==0 does not fire.
  always_ff @(posedge CLK1HZ or negedge nRTCRST) begin
    if (!nRTCRST) begin
      match_shadow_q <= '0;
      ack_q          <= 1'b0;
      raw_int_q      <= 1'b0;
      hit_dly_q      <= 1'b1;
      req_prev_q     <= 1'b0;
    end else begin
      match_shadow_q <= match_shadow_d;
      ack_q          <= ack_d;
      raw_int_q      <= raw_int_d;
      hit_dly_q      <= hit_dly_d;
      req_prev_q     <= req_prev_d;
    end
  end

  // Both AND operands come from PCLK flops, so RTCINTR does not glitch.
  assign bus.MatchValue = match_value_q;
  assign bus.MatchBusy  = busy_q;
  assign bus.RawIntSync = raw_int_s;
  assign bus.RTCINTR    = raw_int_s & bus.IntMask;

endmodule
